// File: rtl/uart_rx_sample_timer_if.sv
// Signal bundle between the UART RX control FSM and its bit/sample timer.
// The control side drives frame setup and the serial line; the timer returns counters and strobes.
interface uart_rx_sample_timer_if #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
);
    localparam int BCW = $clog2(DATA_W + 4);

    logic               EN;
    logic [PRESC_W-1:0] PRESCALE;
    logic               PAR_EN;
    logic               STOP2;
    logic               RX_IN;
    logic [PRESC_W-1:0] EDG_CNT;
    logic [BCW-1:0]     BIT_CNT;
    logic               SMPL_STB;
    logic               SMPL_BIT;
    logic               BIT_END;
    logic               FRAME_DONE;
    logic               PRESC_ERR;

    modport master (
        output EN, PRESCALE, PAR_EN, STOP2, RX_IN,
        input  EDG_CNT, BIT_CNT, SMPL_STB, SMPL_BIT, BIT_END, FRAME_DONE, PRESC_ERR
    );

    modport slave (
        input  EN, PRESCALE, PAR_EN, STOP2, RX_IN,
        output EDG_CNT, BIT_CNT, SMPL_STB, SMPL_BIT, BIT_END, FRAME_DONE, PRESC_ERR
    );
endinterface

// File: rtl/uart_rx_sample_timer.sv
// Oversampling edge/bit counter and mid-bit sampler for a UART receiver.
// Define UART_RX_SMPL_MAJ3_EN to take a 2-of-3 majority around mid-bit instead of a single sample.
module uart_rx_sample_timer #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    uart_rx_sample_timer_if.slave  bus
);
    localparam int BCW = $clog2(DATA_W + 4);
    localparam logic [PRESC_W-1:0] P_MIN = PRESC_W'(4);

    logic [PRESC_W-1:0] r_p;
    logic               r_pe;
    logic               r_s2;
    logic               r_presc_err;
    logic [PRESC_W-1:0] r_edg;
    logic [BCW-1:0]     r_bit;
    logic               r_bit_end;
    logic               r_frame_done;
    logic               r_smpl_stb;
    logic               r_smpl_bit;

    logic               w_run;
    logic [BCW-1:0]     w_frame_len;
    logic [PRESC_W-1:0] w_mid;
    logic               w_edg_last;
    logic               w_bit_last;
    logic               w_smpl_now;
    logic               w_smpl_val;

    assign w_run       = bus.EN & ~r_presc_err;
    assign w_frame_len = BCW'(DATA_W + 2) + BCW'(r_pe) + BCW'(r_s2);
    assign w_mid       = r_p >> 1;
    assign w_edg_last  = (r_edg == (r_p - PRESC_W'(1)));
    assign w_bit_last  = (r_bit == (w_frame_len - BCW'(1)));

`ifdef UART_RX_SMPL_MAJ3_EN
    logic r_cap_lo;
    logic r_cap_mid;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Early and centre captures are pure data; the late one is RX_IN itself on the strobe edge.
    always_ff @(posedge CLK) begin
        if (r_edg == (w_mid - PRESC_W'(1)))
            r_cap_lo <= bus.RX_IN;
        if (r_edg == w_mid)
            r_cap_mid <= bus.RX_IN;
    end

    assign w_smpl_now = (r_edg == (w_mid + PRESC_W'(1)));
    assign w_smpl_val = maj3(r_cap_lo, r_cap_mid, bus.RX_IN);
`else
    assign w_smpl_now = (r_edg == w_mid);
    assign w_smpl_val = bus.RX_IN;
`endif

    // Frame setup is frozen for the whole enabled period so a frame never changes shape mid-flight.
    always_ff @(posedge CLK) begin
        if (RST || !bus.EN) begin
            r_p         <= bus.PRESCALE;
            r_pe        <= bus.PAR_EN;
            r_s2        <= bus.STOP2;
            r_presc_err <= (bus.PRESCALE < P_MIN);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edg        <= '0;
            r_bit        <= '0;
            r_bit_end    <= 1'b0;
            r_frame_done <= 1'b0;
            r_smpl_stb   <= 1'b0;
            r_smpl_bit   <= 1'b0;
        end else if (!w_run) begin
            r_edg        <= '0;
            r_bit        <= '0;
            r_bit_end    <= 1'b0;
            r_frame_done <= 1'b0;
            r_smpl_stb   <= 1'b0;
        end else begin
            r_bit_end    <= w_edg_last;
            r_frame_done <= w_edg_last & w_bit_last;
            r_smpl_stb   <= w_smpl_now;
            if (w_smpl_now)
                r_smpl_bit <= w_smpl_val;
            if (w_edg_last) begin
                r_edg <= '0;
                r_bit <= w_bit_last ? '0 : r_bit + BCW'(1);
            end else begin
                r_edg <= r_edg + PRESC_W'(1);
            end
        end
    end

    assign bus.EDG_CNT    = r_edg;
    assign bus.BIT_CNT    = r_bit;
    assign bus.SMPL_STB   = r_smpl_stb;
    assign bus.SMPL_BIT   = r_smpl_bit;
    assign bus.BIT_END    = r_bit_end;
    assign bus.FRAME_DONE = r_frame_done;
    assign bus.PRESC_ERR  = r_presc_err;
endmodule

// File: tb/tb_uart_rx_sample_timer.sv
// Directed bench for uart_rx_sample_timer; BIT_END/FRAME_DONE and SMPL_STB/SMPL_BIT events are
// predicted into queues when stimulus is applied and matched by a monitor as they appear.
module tb_uart_rx_sample_timer;
    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;
`ifdef UART_RX_SMPL_MAJ3_EN
    localparam int SMP_OFF = 1;
`else
    localparam int SMP_OFF = 0;
`endif

    typedef struct {
        int   cyc;
        logic v;
    } ev_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   n_pass;
    int   n_fail;
    int   n_total;
    logic [15:0] pat;
    ev_t  be_q[$];
    ev_t  st_q[$];

    uart_rx_sample_timer_if #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) bus ();

    uart_rx_sample_timer #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Edge base+k samples EDG_CNT=(k-1)%p inside bit (k-1)/p.
    task automatic plan(input int base, input int p, input int fl, input int edges);
        int e, b;
        for (int k = 1; k <= edges; k++) begin
            e = (k - 1) % p;
            b = (k - 1) / p;
            if (e == p - 1)
                be_q.push_back('{cyc: base + k, v: ((b % fl) == fl - 1)});
            if (e == (p >> 1) + SMP_OFF)
                st_q.push_back('{cyc: base + k, v: pat[b % 16]});
        end
    endtask

    task automatic run_en(input int p, input int fl, input int edges);
        int k;
        plan(cyc, p, fl, edges);
        bus.EN = 1'b1;
        for (int t = 0; t < edges; t++) begin
            bus.RX_IN = pat[(t / p) % 16];
            step();
            k = t + 1;
            check("edg_cnt", 32'(bus.EDG_CNT), k % p);
            if (k % p == 0) begin
                check("bit_cnt", 32'(bus.BIT_CNT), (k / p) % fl);
                check("smpl_hold", 32'(bus.SMPL_BIT), 32'(pat[(k / p - 1) % 16]));
            end
        end
    endtask

    always @(posedge CLK) begin
        ev_t e;
        #1;
        if (bus.BIT_END || bus.FRAME_DONE) begin
            if (be_q.size() == 0) begin
                check("bit_end_unexpected", {30'b0, bus.BIT_END, bus.FRAME_DONE}, 0);
            end else begin
                e = be_q.pop_front();
                check("bit_end_cycle", cyc, e.cyc);
                check("bit_end_pulse", 32'(bus.BIT_END), 1);
                check("frame_done", 32'(bus.FRAME_DONE), 32'(e.v));
            end
        end
        if (bus.SMPL_STB) begin
            if (st_q.size() == 0) begin
                check("strobe_unexpected", 32'(bus.SMPL_STB), 0);
            end else begin
                e = st_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("smpl_bit", 32'(bus.SMPL_BIT), 32'(e.v));
            end
        end
    end

    initial begin
        n_pass = 0;
        n_fail = 0;
        n_total = 0;
        pat = 16'hA5C3;
        RST = 1'b1;
        bus.EN = 1'b0;
        bus.PRESCALE = 6'd2;
        bus.PAR_EN = 1'b0;
        bus.STOP2 = 1'b0;
        bus.RX_IN = 1'b1;

        // Reset state and PRESC_ERR boundary.
        step();
        check("rst_presc_err_p2", 32'(bus.PRESC_ERR), 1);
        check("rst_edg", 32'(bus.EDG_CNT), 0);
        check("rst_bit", 32'(bus.BIT_CNT), 0);
        check("rst_stb", 32'(bus.SMPL_STB), 0);
        check("rst_sbit", 32'(bus.SMPL_BIT), 0);
        check("rst_be", 32'(bus.BIT_END), 0);
        check("rst_fd", 32'(bus.FRAME_DONE), 0);
        bus.PRESCALE = 6'd4;
        step();
        check("rst_presc_err_p4", 32'(bus.PRESC_ERR), 0);
        RST = 1'b0;
        bus.PRESCALE = 6'd8;
        step();
        check("presc_err_p8", 32'(bus.PRESC_ERR), 0);

        // P=8, 8N1: ten bits, one FRAME_DONE.
        run_en(8, 10, 80);
        bus.EN = 1'b0;
        step();
        check("t1_edg_off", 32'(bus.EDG_CNT), 0);
        check("t1_bit_off", 32'(bus.BIT_CNT), 0);

        // P=16 with parity and two stops: FRAME_LEN=12, second frame follows without gap.
        bus.PRESCALE = 6'd16;
        bus.PAR_EN = 1'b1;
        bus.STOP2 = 1'b1;
        step();
        run_en(16, 12, 208);
        bus.EN = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.STOP2 = 1'b0;
        bus.PRESCALE = 6'd8;
        step();

        // Sample point: RX_IN 0/1/0 at EDG_CNT 3/4/5.
        begin
            int base;
            base = cyc;
            be_q.push_back('{cyc: base + 8, v: 1'b0});
`ifdef UART_RX_SMPL_MAJ3_EN
            st_q.push_back('{cyc: base + 6, v: 1'b0});
`else
            st_q.push_back('{cyc: base + 5, v: 1'b1});
`endif
            bus.EN = 1'b1;
            for (int t = 0; t < 8; t++) begin
                bus.RX_IN = (t == 3 || t == 5) ? 1'b0 : 1'b1;
                step();
                if (t == 4 + SMP_OFF)
                    check("strobe_edg_cnt", 32'(bus.EDG_CNT), 5 + SMP_OFF);
            end
            bus.EN = 1'b0;
            bus.RX_IN = 1'b1;
            step();
        end

        // Illegal prescale latched; a change while enabled must not take effect.
        bus.PRESCALE = 6'd3;
        step();
        check("t4_presc_err", 32'(bus.PRESC_ERR), 1);
        bus.EN = 1'b1;
        step();
        bus.PRESCALE = 6'd8;
        for (int t = 0; t < 20; t++) begin
            bus.RX_IN = t[0];
            step();
            check("t4_edg_hold", 32'(bus.EDG_CNT), 0);
            check("t4_bit_hold", 32'(bus.BIT_CNT), 0);
        end
        check("t4_err_still", 32'(bus.PRESC_ERR), 1);
        check("t4_no_stb", 32'(bus.SMPL_STB), 0);
        bus.EN = 1'b0;
        step();
        check("t4_err_clear", 32'(bus.PRESC_ERR), 0);

        // Abort at BIT_CNT=4, EDG_CNT=5.
        run_en(8, 10, 37);
        check("t5_bit", 32'(bus.BIT_CNT), 4);
        check("t5_edg", 32'(bus.EDG_CNT), 5);
        bus.EN = 1'b0;
        step();
        check("t5_edg_abort", 32'(bus.EDG_CNT), 0);
        check("t5_bit_abort", 32'(bus.BIT_CNT), 0);
        repeat (10) step();

        // RST mid-frame with EN still high.
        run_en(8, 10, 13);
        RST = 1'b1;
        step();
        check("t6_edg", 32'(bus.EDG_CNT), 0);
        check("t6_bit", 32'(bus.BIT_CNT), 0);
        check("t6_stb", 32'(bus.SMPL_STB), 0);
        check("t6_sbit", 32'(bus.SMPL_BIT), 0);
        check("t6_be", 32'(bus.BIT_END), 0);
        check("t6_fd", 32'(bus.FRAME_DONE), 0);
        check("t6_err", 32'(bus.PRESC_ERR), 0);
        RST = 1'b0;
        bus.EN = 1'b0;
        repeat (3) step();

        check("be_queue_empty", be_q.size(), 0);
        check("st_queue_empty", st_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
